// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   ldr_state_t     : loader FSM state encoding
//   BYTES_PER_WORD  : stream bytes assembled into one 32-bit instruction word
//   IDX_W           : width of the word index (must reach the full depth, 64)
//   is_loading()    : true in states where the loader owns the memory port
//   takes_bytes()   : true in states where the loader accepts a stream byte
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } ldr_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 7;

  function automatic logic is_loading(input ldr_state_t s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

  function automatic logic takes_bytes(input ldr_state_t s);
    return (s inside {LEN_LO, LEN_HI, DATA, CSUM});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's byte stream, CPU fetch address and instruction-memory
// port into one interface.
//   master : host / CPU / memory side (drives start, stream bytes, cpu_pc)
//   slave  : loader side (drives rx_ready, memory port, status flags)
// Signals:
//   start       single-cycle load request
//   rx_data     stream byte
//   rx_valid    stream byte valid
//   rx_ready    loader accepts a byte this cycle
//   cpu_pc      CPU fetch address
//   imem_addr   memory address (CPU pc when idle, loader address when loading)
//   imem_wdata  word to write
//   imem_we     memory write enable
//   cpu_hold    hold request to the CPU
//   load_done   one-cycle pulse on a successful load
//   load_err    sticky error flag
// -----------------------------------------------------------------------------
interface imem_loader_if;

  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] cpu_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    output start,
    output rx_data,
    output rx_valid,
    output cpu_pc,
    input  rx_ready,
    input  imem_addr,
    input  imem_wdata,
    input  imem_we,
    input  cpu_hold,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  start,
    input  rx_data,
    input  rx_valid,
    input  cpu_pc,
    output rx_ready,
    output imem_addr,
    output imem_wdata,
    output imem_we,
    output cpu_hold,
    output load_done,
    output load_err
  );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Shifts stream bytes into a little-endian 32-bit word: the first byte of a
// word ends up in [7:0], the fourth in [31:24].
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         synchronous clear of the word and byte count
//   byte_valid_i  a byte is transferred this cycle
//   byte_i        the byte
//   word_o        assembled word (complete the cycle after word_valid_o)
//   word_valid_o  the current byte completes a word
// -----------------------------------------------------------------------------
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] word_q;
  logic [1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= 32'h0;
      count_q <= 2'd0;
    end else if (clr_i) begin
      word_q  <= 32'h0;
      count_q <= 2'd0;
    end else if (byte_valid_i) begin
      // Shift right so the oldest byte lands in the low lane after 4 bytes.
      word_q  <= {byte_i, word_q[31:8]};
      count_q <= count_q + 2'd1;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && (count_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Program loader and memory-port arbiter for the instruction memory. Receives
// a framed byte stream (LEN_LO, LEN_HI, 4*N little-endian data bytes, CSUM),
// writes each word to memory while holding the CPU, and passes the CPU fetch
// PC through to the memory when not loading.
// Parameters:
//   DEPTH_WORDS  memory depth in words; frames with N > DEPTH_WORDS are rejected
//   BASE_ADDR    byte address of the first loaded word
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   ldr_if   imem_loader_if.slave (stream, CPU pc, memory port, status)
//
// state  | meaning
// IDLE   | after reset; CPU owns the memory port, waits for start
// LEN_LO | receive low byte of word count N
// LEN_HI | receive high byte of N; range check
// DATA   | receive bytes of the current word
// WRITE  | one-cycle memory write of the assembled word
// CSUM   | receive and compare checksum byte
// DONE   | load succeeded; behaves as IDLE
// ERR    | oversize frame or bad checksum; behaves as IDLE, load_err set
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave ldr_if
);

  ldr_state_t       state_q, state_d;
  logic [7:0]       len_lo_q;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       csum_q;
  logic             rx_ready_q;
  logic             we_q;
  logic             hold_q;
  logic             done_q;
  logic             err_q;

  logic             byte_fire;
  logic             start_ok;
  logic [15:0]      len_w;
  logic             data_byte;
  logic [31:0]      pk_word;
  logic             pk_word_valid;

  assign byte_fire = ldr_if.rx_valid && rx_ready_q;
  assign start_ok  = ldr_if.start && !is_loading(state_q);
  assign len_w     = {ldr_if.rx_data, len_lo_q};
  assign data_byte = byte_fire && (state_q == DATA);

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .byte_valid_i (data_byte),
    .byte_i       (ldr_if.rx_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (ldr_if.start) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (byte_fire) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (byte_fire) begin
          if (len_w > 16'(DEPTH_WORDS)) state_d = ERR;
          else if (len_w == 16'd0)      state_d = CSUM;
          else                          state_d = DATA;
        end
      end
      DATA: begin
        if (pk_word_valid) state_d = WRITE;
      end
      WRITE: begin
        state_d = ((idx_q + 7'd1) == n_q) ? CSUM : DATA;
      end
      CSUM: begin
        if (byte_fire) state_d = (ldr_if.rx_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe, and all drop on the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_lo_q   <= 8'h0;
      n_q        <= '0;
      idx_q      <= '0;
      csum_q     <= 8'h0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= takes_bytes(state_d);
      hold_q     <= is_loading(state_d);
      we_q       <= (state_d == WRITE);
      done_q     <= (state_q == CSUM) && (state_d == DONE);

      if (start_ok) begin
        n_q    <= '0;
        idx_q  <= '0;
        csum_q <= 8'h0;
        err_q  <= 1'b0;
      end

      if ((state_d == ERR) && (state_q != ERR)) err_q <= 1'b1;

      if ((state_q == LEN_LO) && byte_fire) len_lo_q <= ldr_if.rx_data;
      // Only lengths up to DEPTH_WORDS reach DATA/CSUM, so 7 bits suffice.
      if ((state_q == LEN_HI) && byte_fire) n_q <= len_w[IDX_W-1:0];
      if (data_byte) csum_q <= csum_q + ldr_if.rx_data;
      if (state_q == WRITE) idx_q <= idx_q + 7'd1;
    end
  end

  assign ldr_if.rx_ready   = rx_ready_q;
  assign ldr_if.cpu_hold   = hold_q;
  assign ldr_if.load_done  = done_q;
  assign ldr_if.load_err   = err_q;
  assign ldr_if.imem_we    = we_q;
  assign ldr_if.imem_wdata = we_q ? pk_word : 32'h0;
  // The CPU sees its own pc on the memory port whenever the loader is idle.
  assign ldr_if.imem_addr  = hold_q ? (BASE_ADDR + {23'b0, idx_q, 2'b00})
                                    : ldr_if.cpu_pc;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .ldr_if (bus)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  exp_busy = 0;
  bit  exp_err  = 0;
  bit  we_due   = 0;
  bit  done_due = 0;
  bit  run_chk  = 0;
  bit  gaps     = 0;
  int  wr_count = 0;
  int  done_count = 0;
  logic [31:0] last_addr = 32'h0;
  wr_t exp_wr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame contents -> expected words and checksum.
  function automatic logic [31:0] word_of(input bq_t d, input int i);
    return 32'(d[4*i]) + (32'(d[4*i+1]) << 8) + (32'(d[4*i+2]) << 16) + (32'(d[4*i+3]) << 24);
  endfunction

  function automatic logic [7:0] csum_of(input bq_t d);
    int s = 0;
    foreach (d[k]) s += int'(d[k]);
    return 8'(s % 256);
  endfunction

  // Per-cycle compare against the bench's expectations.
  always @(negedge clk) begin
    if (!rst && run_chk) begin
      chk("cpu_hold", {31'b0, bus.cpu_hold}, {31'b0, exp_busy});
      chk("load_err", {31'b0, bus.load_err}, {31'b0, exp_err});
      chk("load_done", {31'b0, bus.load_done}, {31'b0, done_due});
      if (bus.load_done) done_count++;
      done_due = 0;
      if (exp_busy) begin
        chk("imem_we", {31'b0, bus.imem_we}, {31'b0, we_due});
        chk("rx_ready", {31'b0, bus.rx_ready}, {31'b0, !we_due});
        if (bus.imem_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", {31'b0, bus.imem_we}, 32'h0);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("write_addr", bus.imem_addr, w.addr);
            chk("write_data", bus.imem_wdata, w.data);
            last_addr = bus.imem_addr;
            wr_count++;
          end
        end
      end else begin
        chk("idle_we", {31'b0, bus.imem_we}, 32'h0);
        chk("idle_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
        chk("idle_wdata", bus.imem_wdata, 32'h0);
        chk("passthru", bus.imem_addr, bus.cpu_pc);
      end
      we_due = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  budget = 0;
    bit  ok = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        bus.cpu_pc   = $urandom;
        tick();
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!ok && budget < 100) begin
      ok = bus.rx_ready;
      tick();
      budget++;
    end
    bus.rx_valid = 1'b0;
    chk("handshake_timeout", {31'b0, ok}, 32'h1);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_busy  = 1;
    exp_err   = 0;
    chk("start_hold", {31'b0, bus.cpu_hold}, 32'h1);
    chk("start_ready", {31'b0, bus.rx_ready}, 32'h1);
  endtask

  task automatic run_frame(input int n, input bq_t d, input logic [7:0] cs, input bit poke_start);
    do_start();
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    if (n > DEPTH) begin
      exp_busy = 0;
      exp_err  = 1;
    end else begin
      if (poke_start) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (j == 3) begin
            wr_t w;
            w.addr = BASE + 32'(4 * i);
            w.data = word_of(d, i);
            exp_wr.push_back(w);
          end
          send_byte(d[4*i+j]);
          if (j == 3) we_due = 1;
        end
      end
      send_byte(cs);
      exp_busy = 0;
      if (cs == csum_of(d)) done_due = 1;
      else exp_err = 1;
    end
    repeat (3) tick();
    chk("writes_outstanding", exp_wr.size(), 32'h0);
  endtask

  task automatic reset_mid_load(input int nbytes);
    bq_t d;
    int  wr0;
    d = {};
    for (int k = 0; k < 8; k++) d.push_back(8'($urandom));
    wr0 = wr_count;
    do_start();
    send_byte(8'd2);
    send_byte(8'd0);
    for (int k = 0; k < nbytes; k++) send_byte(d[k]);
    bus.cpu_pc = $urandom;
    rst = 1'b1;
    #1;
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
    chk("rst_we", {31'b0, bus.imem_we}, 32'h0);
    chk("rst_wdata", bus.imem_wdata, 32'h0);
    chk("rst_hold", {31'b0, bus.cpu_hold}, 32'h0);
    chk("rst_done", {31'b0, bus.load_done}, 32'h0);
    chk("rst_err", {31'b0, bus.load_err}, 32'h0);
    chk("rst_passthru", bus.imem_addr, bus.cpu_pc);
    exp_wr.delete();
    exp_busy = 0;
    exp_err  = 0;
    we_due   = 0;
    done_due = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_no_write", wr_count, wr0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d2, dz, d64, dr;
    int  wr0, dn0, n;
    logic [7:0] cs;

    bus.start    = 1'b0;
    bus.rx_data  = 8'h0;
    bus.rx_valid = 1'b0;
    bus.cpu_pc   = 32'h1234_5678;

    #12;
    chk("reset_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
    chk("reset_we", {31'b0, bus.imem_we}, 32'h0);
    chk("reset_wdata", bus.imem_wdata, 32'h0);
    chk("reset_hold", {31'b0, bus.cpu_hold}, 32'h0);
    chk("reset_done", {31'b0, bus.load_done}, 32'h0);
    chk("reset_err", {31'b0, bus.load_err}, 32'h0);
    chk("reset_passthru", bus.imem_addr, 32'h1234_5678);
    tick();
    rst = 1'b0;
    run_chk = 1;
    tick();

    bus.cpu_pc = 32'h18;
    #1;
    chk("idle_pc_0x18", bus.imem_addr, 32'h18);
    tick();

    d2 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    chk("model_word0", word_of(d2, 0), 32'h0010_0013);
    chk("model_word1", word_of(d2, 1), 32'h0020_0093);
    chk("model_csum", {24'h0, csum_of(d2)}, 32'hD6);

    // Two-word frame, with a start pulse in the middle that must be ignored.
    wr0 = wr_count; dn0 = done_count;
    run_frame(2, d2, 8'hD6, 1);
    chk("two_word_writes", wr_count - wr0, 32'd2);
    chk("two_word_last_addr", last_addr, 32'h4);
    chk("two_word_done", done_count - dn0, 32'd1);
    chk("two_word_err", {31'b0, bus.load_err}, 32'h0);

    // Bad checksum: both words still land, then ERR.
    wr0 = wr_count; dn0 = done_count;
    run_frame(2, d2, 8'h00, 0);
    chk("bad_csum_writes", wr_count - wr0, 32'd2);
    chk("bad_csum_done", done_count - dn0, 32'd0);
    chk("bad_csum_err", {31'b0, bus.load_err}, 32'h1);

    // Oversize header (N=65): straight to ERR, nothing written.
    dz = {};
    wr0 = wr_count; dn0 = done_count;
    run_frame(65, dz, 8'h00, 0);
    chk("oversize_writes", wr_count - wr0, 32'd0);
    chk("oversize_err", {31'b0, bus.load_err}, 32'h1);

    // Zero-length frame: done with no writes; start clears the error.
    wr0 = wr_count; dn0 = done_count;
    run_frame(0, dz, 8'h00, 0);
    chk("zero_len_writes", wr_count - wr0, 32'd0);
    chk("zero_len_done", done_count - dn0, 32'd1);
    chk("zero_len_err", {31'b0, bus.load_err}, 32'h0);

    // Full-depth frame with random valid gaps.
    gaps = 1;
    d64 = {};
    for (int k = 0; k < 4 * DEPTH; k++) d64.push_back(8'($urandom));
    wr0 = wr_count; dn0 = done_count;
    run_frame(DEPTH, d64, csum_of(d64), 0);
    chk("full_writes", wr_count - wr0, 32'd64);
    chk("full_last_addr", last_addr, 32'hFC);
    chk("full_done", done_count - dn0, 32'd1);

    // Random frames, random checksum correctness.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 6);
      dr = {};
      for (int k = 0; k < 4 * n; k++) dr.push_back(8'($urandom));
      cs = csum_of(dr);
      if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      wr0 = wr_count;
      run_frame(n, dr, cs, 0);
      chk("rand_writes", wr_count - wr0, n);
    end
    gaps = 0;

    reset_mid_load(3);
    reset_mid_load(4);

    bus.cpu_pc = 32'h18;
    #1;
    chk("final_pc_0x18", bus.imem_addr, 32'h18);
    tick();

    run_chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
